// File: rtl/ring_stop_arb_if.sv
// Ring stop bus bundle: upstream ring FIFO head, local injection port,
// ejection port and forward port toward the next stop.
interface ring_stop_arb_if #(
    parameter int WIDTH = 32
);
    logic             iRingVld;
    logic [WIDTH-1:0] iRingDat;
    logic             oRingRdEn;
    logic             iLocVld;
    logic [WIDTH-1:0] iLocDat;
    logic             oLocRdy;
    logic             oEjVld;
    logic [WIDTH-1:0] oEjDat;
    logic             iEjRdy;
    logic             oOutVld;
    logic [WIDTH-1:0] oOutDat;
    logic             iOutFul;

    // Stop-side view.
    modport slave (
        input  iRingVld, iRingDat, iLocVld, iLocDat, iEjRdy, iOutFul,
        output oRingRdEn, oLocRdy, oEjVld, oEjDat, oOutVld, oOutDat
    );

    // Environment-side view (FIFOs, local agent, sink).
    modport master (
        output iRingVld, iRingDat, iLocVld, iLocDat, iEjRdy, iOutFul,
        input  oRingRdEn, oLocRdy, oEjVld, oEjDat, oOutVld, oOutDat
    );
endinterface

// File: rtl/ring_stop_arb.sv
// Ring stop: ejects flits addressed to this node, forwards the rest, and
// arbitrates the forward slot between ring traffic and local injection
// with a starvation override for the local port.
module ring_stop_arb #(
    parameter int WIDTH      = 32,
    parameter int ID_W       = 4,
    parameter int NODE_ID    = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst,
    ring_stop_arb_if.slave bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic             ej_vld;
    logic [WIDTH-1:0] ej_dat;
    logic             out_vld;
    logic [WIDTH-1:0] out_dat;
    logic [3:0]       starveCnt;

    logic ring_is_ej;
    logic ring_ej;
    logic ring_fw;
    logic ej_free;
    logic out_free;
    logic override;
    logic loc_grant;
    logic ej_go;
    logic fw_go;
    logic loc_go;

    // Classify the ring head and decide which transfers happen this cycle.
    always_comb begin
        ring_is_ej = (bus.iRingDat[WIDTH-1 -: ID_W] == ID_W'(NODE_ID));
        ring_ej    = bus.iRingVld && ring_is_ej;
        ring_fw    = bus.iRingVld && !ring_is_ej;
        ej_free    = !ej_vld || bus.iEjRdy;
        out_free   = !out_vld || !bus.iOutFul;
        // Override only matters while a local flit is actually waiting.
        override   = bus.iLocVld && (starveCnt == STARVE_LIM);
        loc_grant  = !ring_fw || override;
        loc_go     = rst && bus.iLocVld && out_free && loc_grant;
        fw_go      = rst && ring_fw && out_free && !override;
        ej_go      = rst && ring_ej && ej_free;
    end

    assign bus.oRingRdEn = ej_go || fw_go;
    assign bus.oLocRdy   = loc_go;
    assign bus.oEjVld    = ej_vld;
    assign bus.oEjDat    = ej_dat;
    assign bus.oOutVld   = out_vld;
    assign bus.oOutDat   = out_dat;

    // Ejection register: load on pop, drop valid once the sink takes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ej_vld <= 1'b0;
            ej_dat <= '0;
        end else if (ej_go) begin
            ej_vld <= 1'b1;
            ej_dat <= bus.iRingDat;
        end else if (ej_vld && bus.iEjRdy) begin
            ej_vld <= 1'b0;
        end
    end

    // Forward register: load the granted flit, clear after a transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (loc_go) begin
            out_vld <= 1'b1;
            out_dat <= bus.iLocDat;
        end else if (fw_go) begin
            out_vld <= 1'b1;
            out_dat <= bus.iRingDat;
        end else if (out_vld && !bus.iOutFul) begin
            out_vld <= 1'b0;
        end
    end

    // Starvation counter: counts blocked local cycles, saturating.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starveCnt <= '0;
        end else if (loc_go) begin
            starveCnt <= '0;
        end else if (bus.iLocVld && (starveCnt != STARVE_LIM)) begin
            starveCnt <= starveCnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_ring_stop_arb.sv
// Directed bench for ring_stop_arb with a flit scoreboard on the eject and
// forward paths.
module tb_ring_stop_arb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    logic [31:0] out_q[$];
    logic [31:0] ej_q[$];

    ring_stop_arb_if #(.WIDTH(32)) bus ();

    ring_stop_arb #(
        .WIDTH(32),
        .ID_W(4),
        .NODE_ID(0),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one cycle, check strobes, score transfers, then advance past the edge.
    task automatic step(input string tag, input logic rv, input logic [31:0] rd,
                        input logic lv, input logic [31:0] ld, input logic er,
                        input logic of, input logic exp_rd, input logic exp_lr);
        logic [31:0] e;
        @(negedge clk);
        bus.iRingVld = rv;
        bus.iRingDat = rd;
        bus.iLocVld  = lv;
        bus.iLocDat  = ld;
        bus.iEjRdy   = er;
        bus.iOutFul  = of;
        #1;
        if (rst && bus.oOutVld && !bus.iOutFul) begin
            chk({tag, "_outq_nonempty"}, 32'(out_q.size() != 0), 32'd1);
            if (out_q.size() != 0) begin
                e = out_q.pop_front();
                chk({tag, "_out_dat"}, bus.oOutDat, e);
            end
        end
        if (rst && bus.oEjVld && bus.iEjRdy) begin
            chk({tag, "_ejq_nonempty"}, 32'(ej_q.size() != 0), 32'd1);
            if (ej_q.size() != 0) begin
                e = ej_q.pop_front();
                chk({tag, "_ej_dat"}, bus.oEjDat, e);
            end
        end
        chk({tag, "_rden"}, 32'(bus.oRingRdEn), 32'(exp_rd));
        chk({tag, "_locrdy"}, 32'(bus.oLocRdy), 32'(exp_lr));
        if (exp_rd) begin
            if (rd[31:28] == 4'd0) ej_q.push_back(rd);
            else out_q.push_back(rd);
        end
        if (exp_lr) out_q.push_back(ld);
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] F1 = 32'h3000_00A1;
    localparam logic [31:0] F2 = 32'h3000_00A2;
    localparam logic [31:0] F3 = 32'h7000_00A3;
    localparam logic [31:0] F4 = 32'h3000_00A4;
    localparam logic [31:0] F5 = 32'h3000_00A5;
    localparam logic [31:0] E1 = 32'h0000_00E1;
    localparam logic [31:0] E2 = 32'h0000_00E2;
    localparam logic [31:0] E3 = 32'h0000_00E3;
    localparam logic [31:0] E4 = 32'h0000_00E4;
    localparam logic [31:0] L1 = 32'h9000_00C1;
    localparam logic [31:0] L2 = 32'h0000_00C2;
    localparam logic [31:0] L3 = 32'h5000_00C3;

    initial begin
        bus.iRingVld = 1'b0;
        bus.iRingDat = '0;
        bus.iLocVld  = 1'b0;
        bus.iLocDat  = '0;
        bus.iEjRdy   = 1'b1;
        bus.iOutFul  = 1'b0;

        // Reset with traffic presented: nothing may be popped or accepted.
        rst = 1'b0;
        step("rst", 1'b1, F1, 1'b1, L1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_outvld", 32'(bus.oOutVld), 32'd0);
        chk("rst_ejvld", 32'(bus.oEjVld), 32'd0);
        chk("rst_outdat", bus.oOutDat, 32'd0);
        chk("rst_ejdat", bus.oEjDat, 32'd0);
        chk("rst_starve", 32'(dut.starveCnt), 32'd0);
        rst = 1'b1;

        // Pass-through of a forward flit.
        step("pt", 1'b1, F1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("pt_outvld", 32'(bus.oOutVld), 32'd1);
        chk("pt_outdat", bus.oOutDat, F1);
        step("pt_idle", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Eject with sink backpressure; second eject flit waits at the head.
        step("ej1", 1'b1, E1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ej1_vld", 32'(bus.oEjVld), 32'd1);
        chk("ej1_dat", bus.oEjDat, E1);
        for (int i = 0; i < 3; i++) begin
            step("ej_stall", 1'b1, E2, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("ej_stall_dat", bus.oEjDat, E1);
            chk("ej_stall_vld", 32'(bus.oEjVld), 32'd1);
        end
        step("ej2", 1'b1, E2, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("ej2_dat", bus.oEjDat, E2);
        step("ej_idle", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ej_idle_vld", 32'(bus.oEjVld), 32'd0);

        // Starvation override: ring wins four cycles, then local gets a slot.
        for (int i = 0; i < 4; i++) begin
            step("stv_ring", 1'b1, 32'h5000_0010 + 32'(i), 1'b1, L1, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        chk("stv_cnt_max", 32'(dut.starveCnt), 32'd4);
        step("stv_loc", 1'b1, 32'h5000_0014, 1'b1, L1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("stv_cnt_clr", 32'(dut.starveCnt), 32'd0);
        chk("stv_outdat", bus.oOutDat, L1);
        step("stv_ring5", 1'b1, 32'h5000_0014, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("stv_idle", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Concurrent eject pop and local inject.
        step("cc", 1'b1, E3, 1'b1, L2, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("cc_ejvld", 32'(bus.oEjVld), 32'd1);
        chk("cc_outvld", 32'(bus.oOutVld), 32'd1);
        step("cc_idle", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Downstream full holds the forward register and blocks both sources.
        step("ful_ld", 1'b1, F2, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step("ful_hold", 1'b1, F3, 1'b1, L3, 1'b1, 1'b1, 1'b0, 1'b0);
            chk("ful_hold_dat", bus.oOutDat, F2);
        end
        step("ful_rel", 1'b1, F3, 1'b1, L3, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("ful_rel_dat", bus.oOutDat, F3);
        chk("ful_rel_starve", 32'(dut.starveCnt), 32'd3);
        step("ful_loc", 1'b0, '0, 1'b1, L3, 1'b1, 1'b0, 1'b0, 1'b1);
        step("ful_idle", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset with both registers full discards their contents.
        step("mr_ej", 1'b1, E4, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("mr_fw", 1'b1, F4, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("mr_blk", 1'b1, F5, 1'b1, L1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("mr_starve_pre", 32'(dut.starveCnt), 32'd1);
        out_q.delete();
        ej_q.delete();
        rst = 1'b0;
        step("mr_rst", 1'b1, F5, 1'b1, L1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mr_outvld", 32'(bus.oOutVld), 32'd0);
        chk("mr_ejvld", 32'(bus.oEjVld), 32'd0);
        chk("mr_starve", 32'(dut.starveCnt), 32'd0);
        rst = 1'b1;
        step("mr_idle", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mr_idle_outvld", 32'(bus.oOutVld), 32'd0);

        chk("end_outq_empty", 32'(out_q.size()), 32'd0);
        chk("end_ejq_empty", 32'(ej_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/ring_stop_arb.md
RING_STOP_ARB -- requirements
Module: ring_stop_arb

Interface
REQ-001 Parameter WIDTH, default 32: flit width in bits.
REQ-002 Parameter ID_W, default 4: destination-ID width; the destination is carried in flit bits [WIDTH-1 -: ID_W].
REQ-003 Parameter NODE_ID, default 0: this stop's ID.
REQ-004 Parameter STARVE_MAX, default 4: number of consecutive blocked local cycles before the local port is forced a slot; legal range 1..15.
REQ-005 clk  in  1  clock; all logic is on the rising edge.
REQ-006 rst  in  1  reset; synchronous and active-low.
REQ-007 iRingVld  in  1  upstream ring FIFO is non-empty (the FIFO's inverted empty flag).
REQ-008 iRingDat  in  WIDTH  head flit of the upstream ring FIFO.
REQ-009 oRingRdEn  out  1  pop strobe to the upstream FIFO; combinational.
REQ-010 iLocVld  in  1  local injection flit valid.
REQ-011 iLocDat  in  WIDTH  local injection flit.
REQ-012 oLocRdy  out  1  local flit accepted this cycle; combinational.
REQ-013 oEjVld  out  1  ejection flit valid; registered.
REQ-014 oEjDat  out  WIDTH  ejection flit; registered.
REQ-015 iEjRdy  in  1  local sink accepts the ejection flit.
REQ-016 oOutVld  out  1  forward flit valid to the next stop's FIFO; registered.
REQ-017 oOutDat  out  WIDTH  forward flit; registered.
REQ-018 iOutFul  in  1  the next stop's FIFO is full; a flit transfers on a cycle with oOutVld=1 and iOutFul=0.

Function
REQ-019 Ring head flit classification:
- "eject" when iRingDat[WIDTH-1 -: ID_W] equals NODE_ID.
- "forward" otherwise.
- Local flits are always forwarded, whatever their destination.
REQ-020 Ejection register (one entry):
- Free when oEjVld=0, or when oEjVld=1 and iEjRdy=1.
- An eject flit is popped and loaded when the register is free.
- When the register is not free, the eject flit stalls at the FIFO head.
REQ-021 Forward register (one entry):
- Slot free when oOutVld=0, or when oOutVld=1 and iOutFul=0.
- Loads the granted flit; otherwise oOutVld clears after a transfer and holds otherwise.
REQ-022 Forward arbitration, evaluated when the slot is free and both a forward ring flit and iLocVld are present:
- The ring wins, unless starveCnt equals STARVE_MAX.
- In that case the local port wins and the ring flit stalls.
REQ-023 starveCnt, 4 bits:
- Increments (saturating at STARVE_MAX) each cycle iLocVld=1 and oLocRdy=0.
- Clears on any cycle oLocRdy=1.
- Holds when iLocVld=0.
REQ-024 oRingRdEn=1 only when iRingVld=1 and the head flit's target register (eject or forward) accepts it this cycle.
REQ-025 oLocRdy=1 only when iLocVld=1, the forward slot is free, and the local port holds the grant.
- The local port holds the grant when no forward ring flit competes, or when the starvation override is active.
REQ-026 Allowed in the same cycle: an eject-flit pop together with a local forward grant (independent resources).
REQ-027 Latency: exactly 1 cycle from an accepting pop or local accept to oEjVld or oOutVld.
REQ-028 No flit is duplicated, dropped, or reordered within a source:
- ring order is preserved on each path;
- local order is preserved.
REQ-029 Registered outputs hold data stable while stalled (oOutVld=1 with iOutFul=1, or oEjVld=1 with iEjRdy=0).

Reset
REQ-030 While rst=0 at a clock edge: oEjVld=0, oEjDat=0, oOutVld=0, oOutDat=0, starveCnt=0.
REQ-031 While rst=0, oRingRdEn=0 and oLocRdy=0 regardless of the inputs.
REQ-032 A flit held in a register when reset asserts mid-operation is discarded; no partial state survives.

Verification
REQ-033 Pass-through: NODE_ID=0, ring flit with dest=3, iOutFul=0 -> oRingRdEn=1 that cycle; next cycle oOutVld=1 and oOutDat equals the flit.
REQ-034 Eject with backpressure: ring flit with dest=0, iEjRdy=0 for 3 cycles -> oEjVld=1 and oEjDat stable; a second eject flit is not popped until iEjRdy=1.
REQ-035 Starvation override: STARVE_MAX=4, continuous forward ring traffic plus iLocVld=1 -> the ring wins 4 cycles; cycle 5 oLocRdy=1 and oRingRdEn=0; starveCnt=0 afterwards.
REQ-036 Concurrent eject and inject: ring eject flit plus a local flit, both registers free -> oRingRdEn=1 and oLocRdy=1 in the same cycle; next cycle oEjVld=1 and oOutVld=1.
REQ-037 Downstream full: iOutFul=1 with oOutVld=1 -> oRingRdEn=0 for forward flits and oLocRdy=0; data held; on release the next flit follows 1 cycle later.
REQ-038 Reset mid-traffic: rst=0 with both registers full -> next edge oOutVld=0, oEjVld=0, starveCnt=0; no pop or accept while rst=0.
